// File: rtl/bitonic_sorter_pkg.sv
// -----------------------------------------------------------------------------
// bitonic_sorter_pkg
// Shared types for the muon sorting chain: the muon_t candidate record and its
// all-zero constant, plus width helpers and the serializer read-FSM state enum
// used by muon_stream_serializer and muon_frame_fifo2.
// -----------------------------------------------------------------------------
package bitonic_sorter_pkg;

  // One muon candidate; sorting key is pt, the remaining fields ride along.
  typedef struct packed {
    logic [8:0] pt;
    logic [8:0] eta;
    logic [9:0] phi;
    logic       charge;
    logic [2:0] qual;
  } muon_t;

  localparam muon_t MUON_ZERO = '0;

  // Read-side state of the serializer.
  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_t;

  // Bits needed to hold a muon count 0..w.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Bits needed to hold a rank 0..w-1 (at least one bit).
  function automatic int index_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muon_frame_fifo2.sv
// -----------------------------------------------------------------------------
// muon_frame_fifo2
// Two-entry FIFO of whole sorted frames {muon_t [0:W-1], effective count}.
// Owns occupancy, write/read pointers and the registered write-ready flag.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_wr_valid      frame offered on i_wr_m / i_wr_count
//   o_wr_ready      registered: occupancy < 2 (0 during reset)
//   i_wr_m          frame muons, index 0 highest rank
//   i_wr_count      effective count already clamped by the caller
//   i_pop           drop the head entry (ignored when empty)
//   o_head_valid    head entry present
//   o_head_m        head entry muons
//   o_head_count    head entry count
//   o_next_valid    an entry will be head once the current head pops; this
//                   includes a frame being written on the same edge
//   o_next_first    index-0 muon of that entry
//   o_next_count    count of that entry
// -----------------------------------------------------------------------------
module muon_frame_fifo2
  import bitonic_sorter_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = count_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  muon_t         i_wr_m [W],
  input  logic [CW-1:0] i_wr_count,
  input  logic          i_pop,
  output logic          o_head_valid,
  output muon_t         o_head_m [W],
  output logic [CW-1:0] o_head_count,
  output logic          o_next_valid,
  output muon_t         o_next_first,
  output logic [CW-1:0] o_next_count
);

  muon_t         r_m     [2][W];
  logic [CW-1:0] r_count [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_occ;
  logic          r_wr_ready;

  logic          w_wr_fire;
  logic          w_pop_fire;
  logic [1:0]    w_occ_nxt;

  assign w_wr_fire  = i_wr_valid && r_wr_ready;
  assign w_pop_fire = i_pop && (r_occ != 2'd0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_wr_fire && !w_pop_fire) begin
      w_occ_nxt = r_occ + 2'd1;
    end else if (!w_wr_fire && w_pop_fire) begin
      w_occ_nxt = r_occ - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_wr_ready <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_fire) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= w_occ_nxt;
      // Ready follows the occupancy after this edge, so a pop cannot open
      // the input in the same cycle it happens.
      r_wr_ready <= (w_occ_nxt != 2'd2);
    end
  end

  // NOTE: frame storage is not reset; occupancy alone says which slots hold data.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int i = 0; i < W; i++) begin
        r_m[r_wr_ptr][i] <= i_wr_m[i];
      end
      r_count[r_wr_ptr] <= i_wr_count;
    end
  end

  assign o_wr_ready   = r_wr_ready;
  assign o_head_valid = (r_occ != 2'd0);
  assign o_head_count = r_count[r_rd_ptr];

  always_comb begin
    for (int i = 0; i < W; i++) begin
      o_head_m[i] = r_m[r_rd_ptr][i];
    end
  end

  // Entry that follows the head: the stored second slot when full, or the
  // frame landing in the free slot on this very edge when only one is held.
  always_comb begin
    o_next_valid = 1'b0;
    o_next_first = r_m[~r_rd_ptr][0];
    o_next_count = r_count[~r_rd_ptr];
    if (r_occ == 2'd2) begin
      o_next_valid = 1'b1;
    end else if ((r_occ == 2'd1) && w_wr_fire) begin
      o_next_valid = 1'b1;
      o_next_first = i_wr_m[0];
      o_next_count = i_wr_count;
    end
  end

endmodule

// File: rtl/muon_stream_serializer.sv
// -----------------------------------------------------------------------------
// muon_stream_serializer
// Turns sorted W-wide muon frames into a valid/ready stream of one muon per
// clock, emitting the first min(count, NOUT) candidates of each frame tagged
// with their rank. A two-frame buffer lets the next frame load while the
// current one drains so consecutive frames stream without bubbles.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     in_m / in_count carry a sorted frame
//   in_ready     frame buffer can accept (registered)
//   in_m         sorted frame, index 0 highest rank
//   in_count     valid muons in the frame, clamped to W
//   out_valid    out_muon is valid
//   out_ready    downstream accepts out_muon
//   out_muon     current muon
//   out_index    rank of out_muon within its frame
//   out_first    out_index == 0
//   out_last     final emitted muon of the frame
// All outputs are registered and hold while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module muon_stream_serializer
  import bitonic_sorter_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int NOUT = 16,
  localparam int CW   = count_width(W),
  localparam int IW   = index_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  muon_t         in_m [W],
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output muon_t         out_muon,
  output logic [IW-1:0] out_index,
  output logic          out_first,
  output logic          out_last
);

  ser_state_t    r_state;
  ser_state_t    w_state_nxt;

  logic          r_out_valid;
  muon_t         r_out_muon;
  logic [IW-1:0] r_out_index;
  logic          r_out_first;
  logic          r_out_last;

  logic          w_valid_nxt;
  muon_t         w_muon_nxt;
  logic [IW-1:0] w_index_nxt;
  logic          w_first_nxt;
  logic          w_last_nxt;

  logic [CW-1:0] w_in_eff;
  logic          w_pop;
  logic [IW-1:0] w_idx_inc;

  logic          w_head_valid;
  muon_t         w_head_m [W];
  logic [CW-1:0] w_head_count;
  logic          w_next_valid;
  muon_t         w_next_first;
  logic [CW-1:0] w_next_count;

  // Effective count stored with the frame: clamp to W, then cap at NOUT.
  always_comb begin
    w_in_eff = in_count;
    if (w_in_eff > CW'(W)) begin
      w_in_eff = CW'(W);
    end
    if (w_in_eff > CW'(NOUT)) begin
      w_in_eff = CW'(NOUT);
    end
  end

  muon_frame_fifo2 #(
    .W  (W),
    .CW (CW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_wr_valid   (in_valid),
    .o_wr_ready   (in_ready),
    .i_wr_m       (in_m),
    .i_wr_count   (w_in_eff),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head_m     (w_head_m),
    .o_head_count (w_head_count),
    .o_next_valid (w_next_valid),
    .o_next_first (w_next_first),
    .o_next_count (w_next_count)
  );

  assign w_idx_inc = r_out_index + IW'(1);

  // Next-state and next-output logic. The output registers double as the
  // rank counter: out_index is the position currently presented.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_valid_nxt = r_out_valid;
    w_muon_nxt  = r_out_muon;
    w_index_nxt = r_out_index;
    w_first_nxt = r_out_first;
    w_last_nxt  = r_out_last;

    unique case (r_state)
      IDLE: begin
        if (w_head_valid) begin
          if (w_head_count != '0) begin
            w_state_nxt = STREAM;
            w_valid_nxt = 1'b1;
            w_muon_nxt  = w_head_m[0];
            w_index_nxt = '0;
            w_first_nxt = 1'b1;
            w_last_nxt  = (w_head_count == CW'(1));
          end else begin
            // Empty frame: retire it silently, one cycle per frame.
            w_pop = 1'b1;
          end
        end
      end

      STREAM: begin
        if (out_ready) begin
          if (r_out_last) begin
            w_pop = 1'b1;
            if (w_next_valid && (w_next_count != '0)) begin
              // Chain straight into the following frame, no bubble.
              w_muon_nxt  = w_next_first;
              w_index_nxt = '0;
              w_first_nxt = 1'b1;
              w_last_nxt  = (w_next_count == CW'(1));
            end else begin
              w_state_nxt = IDLE;
              w_valid_nxt = 1'b0;
              w_first_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end
          end else begin
            w_muon_nxt  = w_head_m[w_idx_inc];
            w_index_nxt = w_idx_inc;
            w_first_nxt = 1'b0;
            w_last_nxt  = ((CW'(w_idx_inc) + CW'(1)) == w_head_count);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_muon  <= MUON_ZERO;
      r_out_index <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_valid_nxt;
      r_out_muon  <= w_muon_nxt;
      r_out_index <= w_index_nxt;
      r_out_first <= w_first_nxt;
      r_out_last  <= w_last_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_muon  = r_out_muon;
  assign out_index = r_out_index;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_muon_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_muon_stream_serializer
// Two serializer instances share the frame data and out_ready: dut0 with
// NOUT=16 and dut1 with NOUT=4. A negedge monitor keeps, per instance, a queue
// of expected beats built from each accepted frame (first min(count,W,NOUT)
// muons with rank and first/last flags) and compares every valid output.
// -----------------------------------------------------------------------------
module tb_muon_stream_serializer;
  import bitonic_sorter_pkg::*;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);

  typedef struct packed {
    muon_t         m;
    logic [IW-1:0] idx;
    logic          first;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_ready;
  muon_t         tb_m [W];
  logic [CW-1:0] tb_count;
  logic          iv [2];
  logic          ir [2];
  logic          ov [2];
  muon_t         om [2];
  logic [IW-1:0] oi [2];
  logic          of_ [2];
  logic          ol [2];

  always #5 clk = ~clk;

  muon_stream_serializer #(.W(W), .NOUT(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_m(tb_m),
    .in_count(tb_count), .out_valid(ov[0]), .out_ready(out_ready),
    .out_muon(om[0]), .out_index(oi[0]), .out_first(of_[0]), .out_last(ol[0])
  );

  muon_stream_serializer #(.W(W), .NOUT(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_m(tb_m),
    .in_count(tb_count), .out_valid(ov[1]), .out_ready(out_ready),
    .out_muon(om[1]), .out_index(oi[1]), .out_first(of_[1]), .out_last(ol[1])
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  int    acc_cnt [2];
  int    vcount  [2];
  int    tx_cnt  [2];
  int    first_cyc [$];
  int    last_cyc  [$];
  beat_t q0 [$];
  beat_t q1 [$];
  logic  stall_prev [2];
  beat_t beat_prev  [2];
  logic  rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input beat_t b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Reference model: on each accepted frame, queue the beats it must emit.
  task automatic model_accept(input int d);
    int    e;
    int    nout;
    beat_t b;
    nout = (d == 0) ? 16 : 4;
    e = int'(tb_count);
    if (e > W)    e = W;
    if (e > nout) e = nout;
    for (int i = 0; i < e; i++) begin
      b.m     = tb_m[i];
      b.idx   = IW'(i);
      b.first = (i == 0);
      b.last  = (i == e - 1);
      qpush(d, b);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      beat_t cur;
      string nm;
      nm        = (d == 0) ? "dut0" : "dut1";
      cur.m     = om[d];
      cur.idx   = oi[d];
      cur.first = of_[d];
      cur.last  = ol[d];
      if (rst) begin
        qclear(d);
        stall_prev[d] = 1'b0;
      end else begin
        if (stall_prev[d]) begin
          check($sformatf("%s_stall_hold", nm), 64'({ov[d], cur}), 64'({1'b1, beat_prev[d]}));
        end
        if (ov[d]) begin
          vcount[d]++;
          if (qsize(d) == 0) begin
            check($sformatf("%s_unexpected_beat", nm), 64'(ov[d]), 64'(0));
          end else begin
            check($sformatf("%s_beat", nm), 64'(cur), 64'(qfront(d)));
            if (out_ready) begin
              tx_cnt[d]++;
              if (d == 0 && cur.first) first_cyc.push_back(cyc);
              if (d == 0 && cur.last)  last_cyc.push_back(cyc);
              qpop(d);
            end
          end
        end
        stall_prev[d] = ov[d] && !out_ready;
        beat_prev[d]  = cur;
        if (iv[d] && ir[d]) begin
          acc_cnt[d]++;
          model_accept(d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_frame(input int count);
    for (int i = 0; i < W; i++) tb_m[i] = muon_t'($urandom);
    tb_count = CW'(count);
  endtask

  // Offer a frame and hold it until the accepting edge has passed.
  task automatic send(input int d, input int count, input string tag);
    int budget;
    budget = 300;
    load_frame(count);
    iv[d] = 1'b1;
    while (!ir[d] && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_accept"}, 64'(ir[d]), 64'(1));
    tick();
    iv[d] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 600;
    while ((qsize(0) != 0 || qsize(1) != 0 || ov[0] || ov[1]) && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_drained"}, 64'(qsize(0) + qsize(1)), 64'(0));
  endtask

  initial begin
    int vb;
    int fc;
    int lc;
    int a;
    int budget;
    for (int d = 0; d < 2; d++) begin
      acc_cnt[d] = 0; vcount[d] = 0; tx_cnt[d] = 0; stall_prev[d] = 1'b0;
      iv[d] = 1'b0;
    end
    rst = 1'b1;
    out_ready = 1'b1;
    load_frame(0);
    repeat (3) tick();

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out_valid%0d", d), 64'(ov[d]), 64'(0));
      check($sformatf("rst_out_first%0d", d), 64'(of_[d]), 64'(0));
      check($sformatf("rst_out_last%0d", d), 64'(ol[d]), 64'(0));
      check($sformatf("rst_out_muon%0d", d), 64'(om[d]), 64'(0));
      check($sformatf("rst_out_index%0d", d), 64'(oi[d]), 64'(0));
      check($sformatf("rst_in_ready%0d", d), 64'(ir[d]), 64'(0));
    end
    rst = 1'b0;
    tick();
    check("release_in_ready0", 64'(ir[0]), 64'(1));
    check("release_in_ready1", 64'(ir[1]), 64'(1));

    // Full frame, one muon per cycle, index 0 one edge after acceptance.
    vb = vcount[0];
    send(0, 16, "t1");
    check("t1_idle_at_accept", 64'(ov[0]), 64'(0));
    tick();
    check("t1_lat_valid", 64'(ov[0]), 64'(1));
    check("t1_lat_index", 64'(oi[0]), 64'(0));
    check("t1_lat_first", 64'(of_[0]), 64'(1));
    drain("t1");
    check("t1_valid_cycles", 64'(vcount[0] - vb), 64'(16));

    // NOUT=4 instance with count 10 emits exactly 4.
    vb = vcount[1];
    send(1, 10, "t2");
    drain("t2");
    check("t2_valid_cycles", 64'(vcount[1] - vb), 64'(4));
    check("t2_idle", 64'(ov[1]), 64'(0));

    // Counts 3, 0, 5 back to back: buffer fills, empty frame is silent.
    vb = vcount[0]; fc = first_cyc.size(); lc = last_cyc.size();
    send(0, 3, "t3a");
    send(0, 0, "t3b");
    check("t3_full_in_ready", 64'(ir[0]), 64'(0));
    send(0, 5, "t3c");
    drain("t3");
    check("t3_valid_cycles", 64'(vcount[0] - vb), 64'(8));
    check("t3_frames", 64'(first_cyc.size() - fc), 64'(2));
    check("t3_idle_gap", 64'((first_cyc[fc + 1] - last_cyc[lc]) >= 2), 64'(1));

    // Second frame buffered early: no bubble between frames.
    fc = first_cyc.size(); lc = last_cyc.size();
    send(0, 4, "t4a");
    send(0, 4, "t4b");
    drain("t4");
    check("t4_no_bubble", 64'(first_cyc[fc + 1]), 64'(last_cyc[lc] + 1));

    // Next frame accepted on the very edge the last muon hands off.
    fc = first_cyc.size(); lc = last_cyc.size();
    send(0, 2, "t5a");
    budget = 20;
    while (!(ov[0] && ol[0]) && budget > 0) begin tick(); budget--; end
    check("t5_last_seen", 64'(ov[0] && ol[0]), 64'(1));
    send(0, 3, "t5b");
    drain("t5");
    check("t5_no_bubble", 64'(first_cyc[fc + 1]), 64'(last_cyc[lc] + 1));

    // Random backpressure on a count-8 frame.
    a = tx_cnt[0];
    send(0, 8, "t6");
    rand_ready = 1'b1;
    drain("t6");
    rand_ready = 1'b0;
    out_ready = 1'b1;
    check("t6_delivered", 64'(tx_cnt[0] - a), 64'(8));

    // Full buffer: head pops on the edge in_valid is high, frame waits a cycle.
    out_ready = 1'b0;
    send(0, 1, "t7a");
    send(0, 1, "t7b");
    check("t7_full", 64'(ir[0]), 64'(0));
    load_frame(2);
    iv[0] = 1'b1;
    out_ready = 1'b1;
    a = acc_cnt[0];
    tick();
    check("t7_not_accepted_on_pop", 64'(acc_cnt[0] - a), 64'(0));
    check("t7_ready_after_pop", 64'(ir[0]), 64'(1));
    tick();
    check("t7_accepted_next", 64'(acc_cnt[0] - a), 64'(1));
    iv[0] = 1'b0;
    drain("t7");

    // Reset in the middle of a frame drops everything buffered.
    send(0, 12, "t8a");
    send(0, 6, "t8b");
    budget = 40;
    while (!(ov[0] && oi[0] == IW'(5)) && budget > 0) begin tick(); budget--; end
    check("t8_reach_idx5", 64'(ov[0] && oi[0] == IW'(5)), 64'(1));
    rst = 1'b1;
    tick();
    check("t8_rst_out_valid", 64'(ov[0]), 64'(0));
    check("t8_rst_out_last", 64'(ol[0]), 64'(0));
    check("t8_rst_in_ready", 64'(ir[0]), 64'(0));
    rst = 1'b0;
    tick();
    check("t8_release_in_ready", 64'(ir[0]), 64'(1));
    for (int i = 0; i < 4; i++) begin
      check("t8_buffer_empty", 64'(ov[0]), 64'(0));
      tick();
    end
    send(0, 3, "t8c");
    tick();
    check("t8_restart_index", 64'(oi[0]), 64'(0));
    check("t8_restart_first", 64'(of_[0]), 64'(1));
    drain("t8");

    // Random frames, counts include 0 and values above W, random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(i % 2, int'($urandom_range(0, 31)), "t9");
    end
    drain("t9");
    rand_ready = 1'b0;
    out_ready = 1'b1;

    check("final_q0_empty", 64'(q0.size()), 64'(0));
    check("final_q1_empty", 64'(q1.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
